// File: rtl/cell_particle_reader_pkg.sv
// Shared definitions for the cell particle reader.
// Holds the position field width and the {posz,posy,posx} word width built
// from it, the default cell depth and address width, and the sequencer states.
package cell_particle_reader_pkg;
  localparam int POS_W            = 32;
  localparam int DEF_DATA_WIDTH   = 3 * POS_W;  // {posz,posy,posx}
  localparam int DEF_PARTICLE_NUM = 220;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_FIFO_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/cell_particle_reader_pos_skid_fifo.sv
// pos_skid_fifo: 2-entry FIFO that holds {position, particle index} entries
// between the cell RAM read port and the force pipeline.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_push, i_din      write one entry (accepted when full only if popping)
//   i_pop              remove head entry (ignored when empty)
//   o_dout             head entry, registered storage
//   o_full, o_empty    occupancy flags
//   o_count            occupancy 0..2
module pos_skid_fifo #(
  parameter int W     = 104,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_mem [DEPTH];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;

  assign o_empty = (r_cnt == 2'd0);
  assign o_full  = (r_cnt == 2'd2);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take a push.
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

// File: rtl/cell_particle_reader.sv
// cell_particle_reader: walks addresses 0..count-1 of one cell position RAM,
// captures the 1-cycle-latency read data and streams {position, index} to
// the force pipeline over valid/ready. Reads are only issued when the skid
// FIFO is guaranteed to have room for the returning word.
// Ports:
//   i_clk, i_rst                   clock, asynchronous active-high reset
//   i_start, i_particle_num        start pulse and particle count (clamped)
//   o_mem_address/o_mem_rden/o_mem_wren, i_mem_q   cell RAM port
//   o_out_valid, i_out_ready, o_out_data, o_out_id  output stream
//   o_busy, o_done                 status; done pulses once per cell
module cell_particle_reader
  import cell_particle_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_particle_num,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_rden,
  output logic                  o_mem_wren,
  input  logic [DATA_WIDTH-1:0] i_mem_q,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic [ADDR_WIDTH-1:0] o_out_id,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int                FW      = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(PARTICLE_NUM);

  state_t                r_state, w_nstate;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH-1:0] r_rd_ptr, r_addr_d;
  logic                  r_inflight;
  logic                  w_issue, w_last, w_pop, w_full, w_empty;
  logic [1:0]            w_fcount;
  logic [2:0]            w_level, w_limit;
  logic [FW-1:0]         w_head;

  assign w_pop   = ~w_empty & i_out_ready;
  // Entries already committed (stored + returning) must stay <= 2 after this
  // cycle's pop, otherwise the issued word would have nowhere to land.
  assign w_level = {1'b0, w_fcount} + {2'b00, r_inflight};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign w_issue = (r_state == ST_READ) && (w_level < w_limit);
  assign w_last  = ({1'b0, r_rd_ptr} == (r_cnt - (ADDR_WIDTH+1)'(1)));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_addr_d   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_inflight <= w_issue;
      if (w_issue) r_addr_d <= r_rd_ptr;
      if (r_state == ST_IDLE && i_start) begin
        r_cnt    <= (i_particle_num > MAX_CNT) ? MAX_CNT : i_particle_num;
        r_rd_ptr <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_nstate = (i_particle_num == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (w_issue && w_last) w_nstate = ST_DRAIN;
      // Leave as the last element is accepted so done follows it directly.
      ST_DRAIN: if (!r_inflight && (w_empty || (!w_full && w_pop))) w_nstate = ST_DONE;
      ST_DONE:  w_nstate = ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase
  end

  pos_skid_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   ({i_mem_q, r_addr_d}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fcount)
  );

  assign o_mem_rden    = w_issue;
  assign o_mem_address = w_issue ? r_rd_ptr : '0;
  assign o_mem_wren    = 1'b0;
  assign o_out_valid   = ~w_empty;
  assign o_out_data    = w_head[FW-1:ADDR_WIDTH];
  assign o_out_id      = w_head[ADDR_WIDTH-1:0];
  assign o_busy        = (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign o_done        = (r_state == ST_DONE);
endmodule

// File: tb/tb_cell_particle_reader.sv
module tb_cell_particle_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  pn = '0;
  logic [7:0]  mem_address;
  logic        mem_rden, mem_wren;
  logic [95:0] mem_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [95:0] out_data;
  logic [7:0]  out_id;
  logic        busy, done;

  cell_particle_reader dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_particle_num(pn),
    .o_mem_address(mem_address), .o_mem_rden(mem_rden), .o_mem_wren(mem_wren),
    .i_mem_q(mem_q), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_id(out_id), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] id; logic [95:0] data; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, t_start = 0;
  int t_rden1, t_valid1, t_last_valid, t_done;
  int done_cnt, acc_cnt, valid_cnt, issued, accepted;
  bit busy_seen, prev_stall;
  logic [95:0] prev_data;
  logic [7:0]  prev_id;
  int ready_mode = 0, ph = 0;

  function automatic logic [95:0] ram_word(input logic [7:0] a);
    logic [31:0] x;
    x = {24'd0, a};
    return {x ^ 32'hC3C3_0000, x * 32'd7 + 32'hB000_0000, x + 32'hA5A5_0000};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Cell RAM model: registered read, 1-cycle latency.
  always @(posedge clk) if (mem_rden) mem_q <= ram_word(mem_address);
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : (ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; issued = 0; accepted = 0;
    end else begin
      if (mem_rden) begin
        issued++;
        if (t_rden1 < 0) t_rden1 = cyc;
      end
      if (out_valid) begin
        valid_cnt++;
        t_last_valid = cyc;
        if (t_valid1 < 0) t_valid1 = cyc;
      end
      if (prev_stall) chk("stall_hold", {out_valid, out_id, out_data}, {1'b1, prev_id, prev_data});
      if (out_valid && out_ready) begin
        accepted++; acc_cnt++;
        if (exp_q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_id", out_id, e.id);
          chk("out_data", out_data, e.data);
        end
      end
      chk("inflight_le2", (issued - accepted) <= 2, 1'b1);
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        if (t_done < 0) t_done = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_id    = out_id;
    end
  end

  task automatic clear_marks();
    t_rden1 = -1; t_valid1 = -1; t_last_valid = -1; t_done = -1;
    done_cnt = 0; acc_cnt = 0; valid_cnt = 0; busy_seen = 0;
  endtask

  task automatic do_start(input int n, input bit expect_data);
    int m;
    @(posedge clk); #1;
    start = 1'b1; pn = 9'(n); t_start = cyc;
    m = (n > 220) ? 220 : n;
    if (expect_data)
      for (int i = 0; i < m; i++) begin
        exp_t e;
        e.id = 8'(i); e.data = ram_word(8'(i));
        exp_q.push_back(e);
      end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string nm);
    int i = 0;
    while (done_cnt == 0 && i < bound) begin
      @(posedge clk); #1; i++;
    end
    if (done_cnt == 0) chk({nm, "_timeout"}, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_once"}, done_cnt, 1);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_addr"}, mem_address, 0);
    chk({nm, "_rden"}, mem_rden, 0);
    chk({nm, "_wren"}, mem_wren, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_id"}, out_id, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    clear_marks();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;

    // 5 elements, ready high: latency and throughput
    clear_marks();
    do_start(5, 1);
    wait_done(30, "n5");
    chk("n5_first_rden", t_rden1 - t_start, 1);
    chk("n5_first_valid", t_valid1 - t_start, 3);
    chk("n5_done_cycle", t_done - t_start, 8);
    chk("n5_valid_cycles", valid_cnt, 5);

    // empty cell
    clear_marks();
    do_start(0, 1);
    wait_done(10, "n0");
    chk("n0_done_lat", (t_done - t_start == 1) || (t_done - t_start == 2), 1'b1);
    chk("n0_busy", busy_seen, 0);
    chk("n0_rden", t_rden1, -1);
    chk("n0_valid", valid_cnt, 0);

    // back-pressure: ready pattern 1,0,0
    clear_marks();
    ready_mode = 1;
    do_start(8, 1);
    wait_done(120, "n8bp");
    chk("n8bp_accepts", acc_cnt, 8);
    ready_mode = 0;

    // full cell, then over-range count
    clear_marks();
    do_start(220, 1);
    wait_done(400, "n220");
    chk("n220_valid_cycles", valid_cnt, 220);
    chk("n220_contiguous", t_last_valid - t_valid1 + 1, 220);
    clear_marks();
    do_start(230, 1);
    wait_done(400, "n230");
    chk("n230_clamped", acc_cnt, 220);

    // reset mid-stream, then a fresh short cell
    clear_marks();
    do_start(10, 1);
    for (int i = 0; i < 30 && acc_cnt < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_reached3", acc_cnt >= 3, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    rst = 1'b0;
    clear_marks();
    do_start(2, 1);
    wait_done(20, "after_rst");
    chk("after_rst_accepts", acc_cnt, 2);

    // start while busy is ignored
    clear_marks();
    do_start(6, 1);
    @(posedge clk); #1;
    start = 1'b1; pn = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(30, "restart");
    chk("restart_accepts", acc_cnt, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
